// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: master drives clr/load/en/up,
// slave returns the registered count and terminal-count pulse.
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output clr, load, load_val, en, up,
    input  count, tc
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output count, tc
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, synchronous clear/load, wrap or
// saturate at the 0..MAX boundaries, and a registered terminal-count pulse.
module mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = (1 << WIDTH) - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_counter_if.slave  bus
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(PRESCALE - 1);
  localparam logic [TW-1:0]    TICK_ONE  = TW'(1);

  logic [WIDTH-1:0] r_count;
  logic [TW-1:0]    r_tick;
  logic             r_tc;

  logic [WIDTH-1:0] w_count_nxt;
  logic [TW-1:0]    w_tick_nxt;
  logic             w_tc_nxt;
  logic             w_step;

  assign w_step = bus.en && (r_tick == TICK_LAST);

  always_comb begin
    w_count_nxt = r_count;
    w_tick_nxt  = r_tick;
    w_tc_nxt    = 1'b0;
    if (bus.clr) begin
      w_count_nxt = '0;
      w_tick_nxt  = '0;
    end else if (bus.load) begin
      w_count_nxt = (bus.load_val > MAXV) ? MAXV : bus.load_val;
      w_tick_nxt  = '0;
    end else if (bus.en) begin
      w_tick_nxt = w_step ? '0 : (r_tick + TICK_ONE);
      if (w_step) begin
        // Boundary detected by explicit compare so MAX = 2**WIDTH-1 never
        // depends on arithmetic overflow.
        if (bus.up) begin
          if (r_count == MAXV) begin
            w_tc_nxt    = 1'b1;
            w_count_nxt = (SATURATE != 0) ? MAXV : '0;
          end else begin
            w_count_nxt = r_count + ONE;
          end
        end else begin
          if (r_count == '0) begin
            w_tc_nxt    = 1'b1;
            w_count_nxt = (SATURATE != 0) ? '0 : MAXV;
          end else begin
            w_count_nxt = r_count - ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tick  <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tick  <= w_tick_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter with prescaler, synchronous clear/load, wrap or saturate mode, and a registered terminal-count pulse. It generalises the free-running 4-bit counter into a reusable timebase and event counter for lab designs: divided ticks, digit counters (MAX=9), and bounded position counters.

## Interface
- WIDTH, 4: count width in bits; WIDTH >= 1.
- MAX, 2**WIDTH-1: top count value; 1 <= MAX <= 2**WIDTH-1. Count range is 0..MAX.
- PRESCALE, 1: enabled cycles per count step; PRESCALE >= 1. PRESCALE=1 means one step per enabled cycle.
- SATURATE, 0: 0 = wrap at boundaries; 1 = hold at boundaries.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; highest synchronous priority.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load; clamped to MAX.
- en  input  1  count enable; gates both the prescaler and the step.
- up  input  1  direction: 1 = increment, 0 = decrement.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide per event.

## Operation
- Internal state: count, prescaler tick counter (width clog2(PRESCALE), min 1 bit), tc register.
- Per-edge priority: clr > load > en-step > hold.
- clr=1: count<=0, tick<=0, tc<=0.
- load=1 (clr=0): count <= (load_val > MAX) ? MAX : load_val; tick<=0; tc<=0.
- en=1, no clr/load: if tick == PRESCALE-1 then tick<=0 and a step occurs; otherwise tick<=tick+1 and count holds.
- en=0: count, tick hold; tc<=0.
- Step, up=1: count<MAX -> count+1. count==MAX -> wrap mode: count<=0, tc<=1; saturate mode: count holds at MAX, tc<=1.
- Step, down (up=0): count>0 -> count-1. count==0 -> wrap mode: count<=MAX, tc<=1; saturate mode: count holds at 0, tc<=1.
- tc<=0 on every edge without a boundary step; back-to-back boundary steps in saturate mode give tc high on consecutive cycles.
- Direction change does not reset the prescaler; tick continues.
- Arithmetic done at WIDTH bits; MAX=2**WIDTH-1 wrap relies on explicit compare, not overflow.
- Count values above MAX are unreachable; no state path produces them.

## Timing
- rst_n low: count=0, tick=0, tc=0 immediately (asynchronous), independent of clk.
- rst_n deassertion: first state change at the first rising edge with rst_n high; synchronisation of rst_n is the integrator's job.
- Reset mid-count or mid-prescale: all progress discarded; counting restarts from 0 with a full PRESCALE interval.
- Latency: inputs sampled at edge N; count and tc valid after edge N. No combinational input-to-output path.
- With en held high: count steps every PRESCALE cycles; first step PRESCALE edges after reset/clr/load.
- Wrap-mode up with en held, PRESCALE=1: tc high once per MAX+1 cycles, in the cycle count shows 0.
- clr and load in the same cycle: clr wins. load with en=1: load wins, no step that cycle.

## Test plan
- WIDTH=4, MAX=9, PRESCALE=1, wrap, up=1, en=1 for 11 edges after reset -> count 1..9,0,1; tc=1 only in the cycle count=0.
- Same config, load_val=0, up=0, one enabled edge -> count=9, tc=1; next edge count=8, tc=0.
- SATURATE=1, MAX=9, load 7, up=1, en=1 for 4 edges -> count 8,9,9,9; tc=0,0,1,1; switch up=0 -> 8, tc=0.
- PRESCALE=3, MAX=15, en=1 for 9 edges with en=0 on edges 4-5 -> count steps only on enabled edges 3 and 6 of the enabled sequence (count=2 after 9 edges with 7 enabled); count frozen while en=0.
- load_val=12 with MAX=9 -> count=9; clr and load together with load_val=5 -> count=0.
- Count to 6 with PRESCALE=3 partway through a tick, pulse rst_n low between clock edges -> count=0, tc=0 immediately; after release, first step 3 edges later.
